// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0_1,
    ST_EOP_SE0_2,
    ST_EOP_J
  } tx_state_t;

  // Differential line pair, dp in the MSB.
  typedef struct packed {
    logic dp;
    logic dm;
  } line_t;

  localparam logic [7:0] SYNC_BYTE       = 8'h80;
  localparam logic [2:0] STUFF_PRE_COUNT = 3'd5;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

endpackage

// File: rtl/nrzi_encoder.sv
// NRZI line encoder: a 0 toggles J/K, a 1 holds the line, se0_force drives SE0.
// Latency: line updates on the same clock edge as the strobe that launches the bit.
// Backpressure: none; follows the strobe unconditionally.
module nrzi_encoder
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic i_bit,
  input  logic i_bit_strobe,
  input  logic i_se0_force,
  output logic o_dplus,
  output logic o_dminus
);

  logic  r_is_k;
  line_t r_line;
  logic  w_next_k;

  assign w_next_k = i_bit ? r_is_k : ~r_is_k;

  // Line state register; SE0 parks the toggle state at J so EOP ends on J.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_is_k <= 1'b0;
      r_line <= LINE_J;
    end else if (i_bit_strobe) begin
      if (i_se0_force) begin
        r_is_k <= 1'b0;
        r_line <= LINE_SE0;
      end else begin
        r_is_k <= w_next_k;
        r_line <= w_next_k ? LINE_K : LINE_J;
      end
    end
  end

  assign o_dplus  = r_line.dp;
  assign o_dminus = r_line.dm;

endmodule

// File: rtl/usb_tx_encoder.sv
// USB packet transmitter: SYNC, bit-stuffed LSB-first payload, NRZI line drive, EOP.
// Latency: first SYNC bit appears after the first bit_strobe following tx_start.
// Backpressure: one-byte holding buffer; tx_data_ready low while full or after the last byte.
module usb_tx_encoder
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic [2:0] bit_stuff_counter,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ready,
  output logic       d_signal,
  output logic       bit_stuff,
  output logic       eop,
  output logic       idle_state,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_error
);

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic       r_started;
  logic       r_cur_last;
  logic [7:0] r_buf;
  logic       r_buf_full;
  logic       r_buf_last;
  logic       r_last_accepted;
  logic       r_d_signal;
  logic       r_bit_stuff;
  logic       r_eop;
  logic       r_idle;
  logic       r_tx_error;

  logic w_active;
  logic w_stuff_now;
  logic w_byte_end;
  logic w_reload;
  logic w_accept;
  logic w_next_bit;
  logic w_next_se0;
  logic w_line_strobe;

  // A bit is on the wire in DATA, and in SYNC once the first strobe has launched bit 0.
  assign w_active    = ((r_state == ST_SYNC) && r_started) || (r_state == ST_DATA);
  assign w_stuff_now = w_active && !r_bit_stuff && r_d_signal &&
                       (bit_stuff_counter == STUFF_PRE_COUNT);
  assign w_byte_end  = w_active && !w_stuff_now && (r_bit_idx == 3'd7);
  assign w_reload    = w_byte_end && !r_cur_last && r_buf_full;

  assign tx_data_ready = !r_buf_full && !r_last_accepted &&
                         ((r_state == ST_SYNC) || (r_state == ST_DATA));
  assign w_accept      = tx_data_valid && tx_data_ready;
  assign w_line_strobe = bit_strobe && (r_state != ST_IDLE);

  // Bit (and SE0) that the coming strobe will launch onto the line.
  always_comb begin
    w_next_bit = 1'b1;
    w_next_se0 = 1'b0;
    case (r_state)
      ST_SYNC, ST_DATA: begin
        if (!w_active) begin
          w_next_bit = r_shift[0];
        end else if (w_stuff_now) begin
          w_next_bit = 1'b0;
        end else if (!w_byte_end) begin
          w_next_bit = r_shift[1];
        end else if (w_reload) begin
          w_next_bit = r_buf[0];
        end else begin
          w_next_se0 = 1'b1;
        end
      end
      ST_EOP_SE0_1: w_next_se0 = 1'b1;
      default: begin
        w_next_bit = 1'b1;
        w_next_se0 = 1'b0;
      end
    endcase
  end

  // Packet FSM, holding buffer and registered status outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state         <= ST_IDLE;
      r_shift         <= 8'd0;
      r_bit_idx       <= 3'd0;
      r_started       <= 1'b0;
      r_cur_last      <= 1'b0;
      r_buf           <= 8'd0;
      r_buf_full      <= 1'b0;
      r_buf_last      <= 1'b0;
      r_last_accepted <= 1'b0;
      r_d_signal      <= 1'b1;
      r_bit_stuff     <= 1'b0;
      r_eop           <= 1'b0;
      r_idle          <= 1'b1;
      r_tx_error      <= 1'b0;
    end else begin
      r_tx_error <= 1'b0;

      if (w_accept) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
        r_buf_last <= tx_last;
        if (tx_last) begin
          r_last_accepted <= 1'b1;
        end
      end

      if (w_line_strobe) begin
        r_d_signal  <= w_next_bit;
        r_bit_stuff <= w_stuff_now;
      end

      case (r_state)
        ST_IDLE: begin
          if (tx_start) begin
            r_state         <= ST_SYNC;
            r_idle          <= 1'b0;
            r_shift         <= SYNC_BYTE;
            r_bit_idx       <= 3'd0;
            r_started       <= 1'b0;
            r_cur_last      <= 1'b0;
            r_buf_full      <= 1'b0;
            r_last_accepted <= 1'b0;
          end
        end
        ST_SYNC, ST_DATA: begin
          if (bit_strobe) begin
            if (!w_active) begin
              r_started <= 1'b1;
            end else if (w_stuff_now) begin
              // Stuff bit: shift register and index hold.
            end else if (!w_byte_end) begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end else if (w_reload) begin
              r_state    <= ST_DATA;
              r_shift    <= r_buf;
              r_bit_idx  <= 3'd0;
              r_cur_last <= r_buf_last;
              r_buf_full <= w_accept;
            end else begin
              // Either the last byte finished or the buffer ran dry.
              r_state    <= ST_EOP_SE0_1;
              r_eop      <= 1'b1;
              r_tx_error <= !r_cur_last;
            end
          end
        end
        ST_EOP_SE0_1: begin
          if (bit_strobe) r_state <= ST_EOP_SE0_2;
        end
        ST_EOP_SE0_2: begin
          if (bit_strobe) r_state <= ST_EOP_J;
        end
        ST_EOP_J: begin
          if (bit_strobe) begin
            r_state <= ST_IDLE;
            r_eop   <= 1'b0;
            r_idle  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  nrzi_encoder u_nrzi (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_bit        (w_next_bit),
    .i_bit_strobe (w_line_strobe),
    .i_se0_force  (w_next_se0),
    .o_dplus      (dplus_out),
    .o_dminus     (dminus_out)
  );

  assign d_signal   = r_d_signal;
  assign bit_stuff  = r_bit_stuff;
  assign eop        = r_eop;
  assign idle_state = r_idle;
  assign tx_error   = r_tx_error;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench: a bit-level reference model fills an expected queue per packet,
// a monitor compares every presented bit time, and an in-bench bit stuffer closes the loop.
module tb_usb_tx_encoder;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       bit_strobe;
  logic [2:0] bit_stuff_counter;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_last;
  logic       tx_data_ready;
  logic       d_signal;
  logic       bit_stuff;
  logic       eop;
  logic       idle_state;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_error;

  always #5 clk = ~clk;

  usb_tx_encoder dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .bit_strobe        (bit_strobe),
    .bit_stuff_counter (bit_stuff_counter),
    .tx_start          (tx_start),
    .tx_data           (tx_data),
    .tx_data_valid     (tx_data_valid),
    .tx_last           (tx_last),
    .tx_data_ready     (tx_data_ready),
    .d_signal          (d_signal),
    .bit_stuff         (bit_stuff),
    .eop               (eop),
    .idle_state        (idle_state),
    .dplus_out         (dplus_out),
    .dminus_out        (dminus_out),
    .tx_error          (tx_error)
  );

  int n_pass = 0;
  int n_total = 0;
  int err_cnt = 0;
  int start_req = 0;
  int start_done = 0;
  bit mon_en = 1'b1;
  logic [4:0] exp_q[$];   // {d_signal, bit_stuff, eop, dplus, dminus}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Strobe generator (period 3..6 clocks); tx_start requests are placed on non-strobe cycles.
  initial begin
    int gap;
    gap = 2;
    bit_strobe = 1'b0;
    tx_start = 1'b0;
    forever begin
      @(negedge clk);
      bit_strobe = 1'b0;
      tx_start = 1'b0;
      if (gap == 0) begin
        bit_strobe = 1'b1;
        gap = $urandom_range(2, 5);
      end else begin
        gap--;
        if (start_req != start_done) begin
          tx_start = 1'b1;
          start_done++;
        end
      end
    end
  end

  // External bit stuffer: run length of completed non-stuffed 1s, saturating.
  always @(posedge clk) begin
    if (!n_rst) bit_stuff_counter <= 3'd0;
    else if (bit_strobe)
      bit_stuff_counter <= (d_signal && !bit_stuff) ?
                           ((bit_stuff_counter == 3'd7) ? 3'd7 : bit_stuff_counter + 3'd1) : 3'd0;
  end

  // Monitor: one expected entry per bit time launched by a strobe while not idle.
  initial begin
    forever begin : mon
      logic s;
      logic [4:0] a;
      logic [4:0] e;
      @(posedge clk);
      s = bit_strobe;
      #1;
      if (n_rst && tx_error) begin
        err_cnt++;
        check("tx_error_with_eop", eop, 1);
      end
      if (s && mon_en && !idle_state) begin
        a = {d_signal, bit_stuff, eop, dplus_out, dminus_out};
        check("exp_available", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("bit_time", a, e);
        end
      end
    end
  end

  // Reference: SYNC + payload bits, insert a 0 after every six 1s, NRZI from J, then EOP.
  task automatic push_expect(input logic [7:0] bytes_in[$]);
    bit raw[$];
    bit val[$];
    bit stf[$];
    int ones;
    bit k;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    foreach (bytes_in[b]) for (int j = 0; j < 8; j++) raw.push_back(bytes_in[b][j]);
    ones = 0;
    foreach (raw[i]) begin
      val.push_back(raw[i]);
      stf.push_back(1'b0);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        val.push_back(1'b0);
        stf.push_back(1'b1);
        ones = 0;
      end
    end
    k = 1'b0;
    foreach (val[i]) begin
      if (!val[i]) k = !k;
      exp_q.push_back({val[i], stf[i], 1'b0, !k, k});
    end
    exp_q.push_back(5'b10100);
    exp_q.push_back(5'b10100);
    exp_q.push_back(5'b10110);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int t;
    t = 0;
    @(negedge clk);
    tx_data = b;
    tx_last = last;
    tx_data_valid = 1'b1;
    while (!tx_data_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("byte_accepted_in_time", t < 3000, 1);
    @(negedge clk);
    tx_data_valid = 1'b0;
    tx_last = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!idle_state && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("idle_in_time", t < 5000, 1);
  endtask

  task automatic check_reset_values();
    check("rst_idle_state", idle_state, 1);
    check("rst_dplus", dplus_out, 1);
    check("rst_dminus", dminus_out, 0);
    check("rst_d_signal", d_signal, 1);
    check("rst_bit_stuff", bit_stuff, 0);
    check("rst_eop", eop, 0);
    check("rst_tx_error", tx_error, 0);
    check("rst_ready", tx_data_ready, 0);
  endtask

  task automatic run_packet(input logic [7:0] bytes_in[$], input bit underrun, input bit poke_eop);
    int err0;
    int t;
    bit stayed;
    push_expect(bytes_in);
    err0 = err_cnt;
    start_req++;
    foreach (bytes_in[i]) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send_byte(bytes_in[i], !underrun && (i == bytes_in.size() - 1));
    end
    if (poke_eop) begin
      t = 0;
      while (!eop && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check("eop_seen", eop, 1);
      do @(posedge clk); while (!bit_strobe);
      start_req++;
    end
    wait_idle();
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("tx_error_pulses", err_cnt - err0, underrun ? 1 : 0);
    check("idle_after_packet", idle_state, 1);
    if (poke_eop) begin
      stayed = 1'b1;
      repeat (60) begin
        @(negedge clk);
        if (!idle_state) stayed = 1'b0;
      end
      check("start_request_driven", start_done, start_req);
      check("no_second_sync", stayed, 1);
    end
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] q[$];
    int n;
    tx_data = 8'd0;
    tx_data_valid = 1'b0;
    tx_last = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    n_rst = 1'b1;

    q.delete(); q.push_back(8'hA5);
    run_packet(q, 0, 0);
    q.delete(); q.push_back(8'hFF);
    run_packet(q, 0, 0);
    q.delete(); q.push_back(8'h3F); q.push_back(8'hFF);
    run_packet(q, 0, 0);
    q.delete(); q.push_back(8'h5C);
    run_packet(q, 1, 0);

    // Reset in the middle of the first payload byte.
    mon_en = 1'b0;
    start_req++;
    send_byte(8'h6B, 1'b0);
    n = 0;
    while (n < 12) begin
      @(posedge clk);
      if (bit_strobe) n++;
    end
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    n_rst = 1'b1;
    mon_en = 1'b1;
    q.delete(); q.push_back(8'hC3); q.push_back(8'h7E);
    run_packet(q, 0, 0);

    // tx_start during the second SE0 bit time must be ignored.
    q.delete(); q.push_back(8'h01); q.push_back(8'hFE);
    run_packet(q, 0, 1);

    for (int p = 0; p < 8; p++) begin
      q.delete();
      n = $urandom_range(1, 3);
      for (int b = 0; b < n; b++)
        q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      run_packet(q, $urandom_range(0, 5) == 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
